// File: rtl/rf_wr_arb.sv
// rf_wr_arb: round-robin arbiter for the single register-file write port, plus a
// per-register pending-write scoreboard that stalls issue on RAW/WAW hazards.
module rf_wr_arb #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  // issue-stage reservation and source reads
  input  logic              rsv_valid,
  input  logic [SEL_W-1:0]  rsv_sel,
  input  logic              read1_en,
  input  logic              read2_en,
  input  logic [SEL_W-1:0]  read1regsel,
  input  logic [SEL_W-1:0]  read2regsel,
  // writeback sources
  input  logic              req0_valid,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  input  logic [SEL_W-1:0]  req1_sel,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req0_ready,
  output logic              req1_ready,
  // register-file write port
  output logic [SEL_W-1:0]  writeregsel,
  output logic [DATA_W-1:0] writedata,
  output logic              write,
  // status
  output logic [2**SEL_W-1:0] pending,
  output logic              stall,
  output logic              err
);

  localparam int unsigned NReg = 2**SEL_W;

  logic              last0_q, last0_d;   // 1: req0 won the last accept, so req1 is favoured
  logic              write_q, write_d;
  logic [SEL_W-1:0]  wsel_q, wsel_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NReg-1:0]   pend_q, pend_d;
  logic              err_q, err_d;

  logic              gnt0, gnt1, accept;
  logic [SEL_W-1:0]  win_sel;
  logic [DATA_W-1:0] win_data;

  // Grant: a lone requester wins; under contention the source not granted last wins.
  always_comb begin
    gnt0     = req0_valid & (~req1_valid | ~last0_q);
    gnt1     = req1_valid & ~gnt0;
    accept   = gnt0 | gnt1;
    win_sel  = gnt0 ? req0_sel  : req1_sel;
    win_data = gnt0 ? req0_data : req1_data;
  end

  // Hazard stall from the scoreboard; a stalled reservation is not taken.
  always_comb begin
    stall = (read1_en  & pend_q[read1regsel]) |
            (read2_en  & pend_q[read2regsel]) |
            (rsv_valid & pend_q[rsv_sel]);
  end

  // Next-state for write port, pointer, scoreboard and error flag.
  always_comb begin
    last0_d = last0_q;
    write_d = accept;
    wsel_d  = wsel_q;
    wdata_d = wdata_q;
    pend_d  = pend_q;
    err_d   = err_q;
    if (accept) begin
      last0_d = gnt0;
      wsel_d  = win_sel;
      wdata_d = win_data;
      if (!pend_q[win_sel]) begin
        err_d = 1'b1;
      end
    end
    // Clear the landing write; a same-register set is impossible here since stall is high.
    if (write_q) begin
      pend_d[wsel_q] = 1'b0;
    end
    if (rsv_valid && !stall) begin
      pend_d[rsv_sel] = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last0_q <= 1'b0;
      write_q <= 1'b0;
      wsel_q  <= '0;
      wdata_q <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      last0_q <= last0_d;
      write_q <= write_d;
      wsel_q  <= wsel_d;
      wdata_q <= wdata_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  // Output mapping.
  always_comb begin
    req0_ready  = gnt0;
    req1_ready  = gnt1;
    write       = write_q;
    writeregsel = wsel_q;
    writedata   = wdata_q;
    pending     = pend_q;
    err         = err_q;
  end

endmodule

// File: tb/tb_rf_wr_arb.sv
// Directed self-checking bench for rf_wr_arb.
module tb_rf_wr_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        rsv_valid;
  logic [2:0]  rsv_sel;
  logic        read1_en, read2_en;
  logic [2:0]  read1regsel, read2regsel;
  logic        req0_valid, req1_valid;
  logic [2:0]  req0_sel, req1_sel;
  logic [15:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic [2:0]  writeregsel;
  logic [15:0] writedata;
  logic        write;
  logic [7:0]  pending;
  logic        stall;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rf_wr_arb dut (
    .clk         (clk),
    .rst         (rst),
    .rsv_valid   (rsv_valid),
    .rsv_sel     (rsv_sel),
    .read1_en    (read1_en),
    .read2_en    (read2_en),
    .read1regsel (read1regsel),
    .read2regsel (read2regsel),
    .req0_valid  (req0_valid),
    .req0_sel    (req0_sel),
    .req0_data   (req0_data),
    .req1_valid  (req1_valid),
    .req1_sel    (req1_sel),
    .req1_data   (req1_data),
    .req0_ready  (req0_ready),
    .req1_ready  (req1_ready),
    .writeregsel (writeregsel),
    .writedata   (writedata),
    .write       (write),
    .pending     (pending),
    .stall       (stall),
    .err         (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rsv_valid = 0; rsv_sel = 0;
    read1_en = 0; read2_en = 0; read1regsel = 0; read2regsel = 0;
    req0_valid = 0; req0_sel = 0; req0_data = 0;
    req1_valid = 0; req1_sel = 0; req1_data = 0;
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    #12;
    rst = 1'b1;
    cyc();
    #1;
    chk("rst_pending", pending, 0);
    chk("rst_write", write, 0);
    chk("rst_wsel", writeregsel, 0);
    chk("rst_wdata", writedata, 0);
    chk("rst_err", err, 0);
    chk("rst_stall", stall, 0);

    // Single write: reserve r3, req0 writes 0xBEEF
    rsv_valid = 1; rsv_sel = 3; #1;
    chk("t1_rsv_stall", stall, 0);
    cyc();
    rsv_valid = 0; req0_valid = 1; req0_sel = 3; req0_data = 16'hBEEF; #1;
    chk("t1_pending_set", pending, 8'h08);
    chk("t1_ready0", req0_ready, 1);
    chk("t1_ready1", req1_ready, 0);
    chk("t1_write_lo", write, 0);
    cyc();
    req0_valid = 0; #1;
    chk("t1_write", write, 1);
    chk("t1_wsel", writeregsel, 3);
    chk("t1_wdata", writedata, 16'hBEEF);
    chk("t1_pending_hold", pending, 8'h08);
    cyc(); #1;
    chk("t1_pending_clr", pending, 0);
    chk("t1_write_off", write, 0);
    chk("t1_wdata_hold", writedata, 16'hBEEF);
    chk("t1_err", err, 0);

    // RAW stall on r5, plus a WAW reserve while pending
    rsv_valid = 1; rsv_sel = 5;
    cyc();
    read1_en = 1; read1regsel = 5; #1;
    chk("t2_stall_a", stall, 1);
    chk("t2_pending", pending, 8'h20);
    cyc();
    rsv_valid = 0; req1_valid = 1; req1_sel = 5; req1_data = 16'h1234; #1;
    chk("t2_pend_unchg", pending, 8'h20);
    chk("t2_stall_b", stall, 1);
    chk("t2_ready1", req1_ready, 1);
    cyc();
    req1_valid = 0; #1;
    chk("t2_write", write, 1);
    chk("t2_wsel", writeregsel, 5);
    chk("t2_stall_c", stall, 1);
    cyc(); #1;
    chk("t2_stall_off", stall, 0);
    chk("t2_pending_clr", pending, 0);
    read1_en = 0;

    // Round-robin: reserve r1,r2,r4,r6 then contend
    rsv_valid = 1; rsv_sel = 1; cyc();
    rsv_sel = 2; cyc();
    rsv_sel = 4; cyc();
    rsv_sel = 6; cyc();
    rsv_valid = 0; #1;
    chk("t3_pending", pending, 8'h56);
    req0_valid = 1; req0_sel = 1; req0_data = 16'h0101;
    req1_valid = 1; req1_sel = 2; req1_data = 16'h0202; #1;
    chk("t3_g0_r0", req0_ready, 1);
    chk("t3_g0_r1", req1_ready, 0);
    cyc();
    req0_sel = 4; req0_data = 16'h0404; #1;
    chk("t3_g1_r0", req0_ready, 0);
    chk("t3_g1_r1", req1_ready, 1);
    chk("t3_w1", write, 1);
    chk("t3_w1_sel", writeregsel, 1);
    cyc();
    req1_sel = 6; req1_data = 16'h0606; #1;
    chk("t3_g2_r0", req0_ready, 1);
    chk("t3_g2_r1", req1_ready, 0);
    chk("t3_w2", write, 1);
    chk("t3_w2_sel", writeregsel, 2);
    cyc();
    req0_valid = 0; #1;
    chk("t3_g3_r0", req0_ready, 0);
    chk("t3_g3_r1", req1_ready, 1);
    chk("t3_w3", write, 1);
    chk("t3_w3_sel", writeregsel, 4);
    cyc();
    req1_valid = 0; #1;
    chk("t3_w4", write, 1);
    chk("t3_w4_sel", writeregsel, 6);
    chk("t3_w4_data", writedata, 16'h0606);
    cyc(); #1;
    chk("t3_w_off", write, 0);
    chk("t3_pending_clr", pending, 0);
    chk("t3_err", err, 0);

    // Error: req1 writes r7 with no reservation
    req1_valid = 1; req1_sel = 7; req1_data = 16'h7777; #1;
    chk("t4_ready1", req1_ready, 1);
    chk("t4_err_pre", err, 0);
    cyc();
    req1_valid = 0; #1;
    chk("t4_write", write, 1);
    chk("t4_wsel", writeregsel, 7);
    chk("t4_wdata", writedata, 16'h7777);
    chk("t4_err_set", err, 1);
    cyc(); cyc(); #1;
    chk("t4_err_sticky", err, 1);

    // Async reset during a write with pending=0x0C
    rsv_valid = 1; rsv_sel = 2; cyc();
    rsv_sel = 3; cyc();
    rsv_valid = 0; req0_valid = 1; req0_sel = 2; req0_data = 16'hCAFE; #1;
    chk("t5_ready0", req0_ready, 1);
    cyc();
    req0_valid = 0; #1;
    chk("t5_write_pre", write, 1);
    chk("t5_pending_pre", pending, 8'h0C);
    rst = 1'b0; #1;
    chk("t5_write_rst", write, 0);
    chk("t5_pending_rst", pending, 0);
    chk("t5_err_rst", err, 0);
    chk("t5_wsel_rst", writeregsel, 0);
    #2;
    rst = 1'b1;
    cyc();
    req0_valid = 1; req0_sel = 0; req1_valid = 1; req1_sel = 1; #1;
    chk("t5_post_r0", req0_ready, 1);
    chk("t5_post_r1", req1_ready, 0);
    idle();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rf_wr_arb.md
# rf_wr_arb

Write-port arbiter and scoreboard for the 8x16 register file. It shares the single register-file write port between two writeback sources: the in-order pipeline writeback (req0) and a multi-cycle unit such as the multiplier or load return (req1). Arbitration is round-robin. It tracks one pending-write bit per register, which it sets when the issue stage reserves a destination and clears when the write lands. From those bits it drives the issue-stage stall for RAW and WAW hazards, because the register file has no write-to-read bypass.

## Interface
- DATA_W, 16, write data width (fixed to the register-file width)
- SEL_W, 3, register selector width (8 registers)

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-low
- rsv_valid  in  1  issue stage wants to reserve destination rsv_sel
- rsv_sel  in  3  destination register to reserve
- read1_en, read2_en  in  1  source operand read1regsel/read2regsel is used
- read1regsel, read2regsel  in  3  issue-stage source selectors (same values sent to the register file)
- req0_valid, req1_valid  in  1  write request from source 0/1
- req0_sel, req1_sel  in  3  target register
- req0_data, req1_data  in  16  write data
- req0_ready, req1_ready  out  1  request accepted this cycle (combinational)
- writeregsel  out  3  register-file write selector (registered)
- writedata  out  16  register-file write data (registered)
- write  out  1  register-file write enable (registered)
- pending  out  8  scoreboard bits, bit i set means register i awaits a write
- stall  out  1  issue must hold; reservation not taken (combinational)
- err  out  1  sticky protocol error

## Operation
- Arbitration
  - Only one request is accepted per cycle.
  - If only one request is valid, that request wins.
  - If both are valid, the source not granted last wins.
  - The last-grant pointer updates only on an accept.
  - After reset the pointer favours req0.
  - reqN_ready equals that source's grant.
  - A requester holds valid, sel and data stable until it sees ready.
- Write port
  - On accept, the winner's sel and data are registered to writeregsel/writedata, and write is set for exactly one cycle.
  - write=0 in any cycle with no accept.
  - writeregsel/writedata hold their last value when write=0.
- Stall
  - stall = (read1_en & pending[read1regsel]) | (read2_en & pending[read2regsel]) | (rsv_valid & pending[rsv_sel]).
- Scoreboard set
  - pending[rsv_sel] is set when rsv_valid=1 and stall=0.
  - No reservation occurs while stall=1.
- Scoreboard clear
  - pending[writeregsel] is cleared at the edge ending a cycle with write=1.
  - A same-cycle set of the same register cannot occur, because that register is still pending, so stall=1.
  - Set and clear of different registers in the same cycle both take effect.
- err
  - Set on accepting a request whose target register has its pending bit at 0.
  - Stays set until reset.
  - The write is still performed.
- Reset (asynchronous, any time, including mid-transfer)
  - pending=0, write=0, writeregsel=0, writedata=0, err=0, pointer favours req0.
  - Un-accepted requests are dropped; requesters re-present them after reset.

## Timing
- Request accepted in cycle N → write=1 in cycle N+1 → register file captures at the end of N+1 → data readable in N+2.
- The pending bit falls at the end of N+1, so stall on that register deasserts in cycle N+2, matching read availability.
- Reservation in cycle M → pending set from M+1 → a dependent read stalls from M+1.
- Minimum reserve-to-unstall time: 3 cycles (reserve M, accept M+1, write M+2, readable M+3).
- Sustained throughput: one write per cycle. With both sources always valid, grants alternate 0,1,0,1.
- ready, stall: combinational, same cycle. All other outputs are registered.

## Test plan
- Reset then single write
  - Stimulus: reserve r3 (cycle 0); req0 r3 with data 0xBEEF (cycle 1).
  - Response: req0_ready=1 in cycle 1; write=1, writeregsel=3, writedata=0xBEEF in cycle 2; pending=0x00 from cycle 3; err=0.
- RAW stall
  - Stimulus: reserve r5, then hold read1_en=1, read1regsel=5; req1 writes r5 two cycles later.
  - Response: stall=1 until the cycle after write=1, then 0.
  - Also check: a reserve of r5 while pending gives stall=1 and pending unchanged.
- Round-robin contention
  - Stimulus: pending r1,r2,r4,r6; req0 and req1 both valid continuously with distinct targets.
  - Response: grants alternate starting with req0; exactly one ready per cycle; write stays high four consecutive cycles.
- Error detection
  - Stimulus: req1 writes r7 with pending[7]=0.
  - Response: write performed; err=1 from the next cycle and stays 1 until rst low.
- Asynchronous reset mid-operation
  - Stimulus: assert rst low during the cycle with write=1 and pending=0x0C.
  - Response: write, pending and err are 0 immediately; after release, the first contended grant goes to req0.
